// File: rtl/taillight_pkg.sv
// Shared types, lamp pattern constants and the combinational decode used by the
// tail-light pattern monitor.
package taillight_pkg;

    typedef enum logic [3:0] {
        PatOff,
        PatL1,
        PatL2,
        PatL3,
        PatR1,
        PatR2,
        PatR3,
        PatH1,
        PatH2,
        PatH3,
        PatIllegal
    } lamp_pat_t;

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeLeft  = 2'd1,
        ModeRight = 2'd2,
        ModeHaz   = 2'd3
    } mode_t;

    // Vector order is {LA, LB, LC, RA, RB, RC}.
    localparam logic [5:0] LampOff = 6'b000_000;
    localparam logic [5:0] LampL1  = 6'b100_000;
    localparam logic [5:0] LampL2  = 6'b110_000;
    localparam logic [5:0] LampL3  = 6'b111_000;
    localparam logic [5:0] LampR1  = 6'b000_100;
    localparam logic [5:0] LampR2  = 6'b000_110;
    localparam logic [5:0] LampR3  = 6'b000_111;
    localparam logic [5:0] LampH1  = 6'b100_100;
    localparam logic [5:0] LampH2  = 6'b110_110;
    localparam logic [5:0] LampH3  = 6'b111_111;

    function automatic lamp_pat_t decode_lamps(input logic [5:0] v);
        lamp_pat_t p;
        case (v)
            LampOff: p = PatOff;
            LampL1:  p = PatL1;
            LampL2:  p = PatL2;
            LampL3:  p = PatL3;
            LampR1:  p = PatR1;
            LampR2:  p = PatR2;
            LampR3:  p = PatR3;
            LampH1:  p = PatH1;
            LampH2:  p = PatH2;
            LampH3:  p = PatH3;
            default: p = PatIllegal;
        endcase
        return p;
    endfunction

    function automatic mode_t pat_mode(input lamp_pat_t p);
        mode_t m;
        case (p)
            PatL1, PatL2, PatL3: m = ModeLeft;
            PatR1, PatR2, PatR3: m = ModeRight;
            PatH1, PatH2, PatH3: m = ModeHaz;
            default:             m = ModeOff;
        endcase
        return m;
    endfunction

    // OFF and ILLEGAL both report phase 0.
    function automatic logic [1:0] pat_phase(input lamp_pat_t p);
        logic [1:0] ph;
        case (p)
            PatL1, PatR1, PatH1: ph = 2'd1;
            PatL2, PatR2, PatH2: ph = 2'd2;
            PatL3, PatR3, PatH3: ph = 2'd3;
            default:             ph = 2'd0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/taillight_pattern_monitor_if.sv
// Lamp inputs, clear and status outputs of the tail-light pattern monitor.
interface taillight_pattern_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             LA;
    logic             LB;
    logic             LC;
    logic             RA;
    logic             RB;
    logic             RC;
    logic             clr;
    logic [1:0]       mode;
    logic [1:0]       phase;
    logic             done;
    logic             err;
    logic             err_flag;
    logic             in_sync;
    logic [CNT_W-1:0] left_cnt;
    logic [CNT_W-1:0] right_cnt;
    logic [CNT_W-1:0] haz_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output LA, LB, LC, RA, RB, RC, clr,
        input  mode, phase, done, err, err_flag, in_sync,
        input  left_cnt, right_cnt, haz_cnt, err_cnt
    );

    modport slave (
        input  LA, LB, LC, RA, RB, RC, clr,
        output mode, phase, done, err, err_flag, in_sync,
        output left_cnt, right_cnt, haz_cnt, err_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coincident with clear
// leaves the count at 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] Max = '1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= W'(inc);
        end else if (inc && (r_count != Max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule

// File: rtl/taillight_pattern_monitor.sv
// Receiving-end checker for the six-lamp tail-light bus: decodes mode/phase, enforces the
// X1->X2->X3->OFF grammar and counts completed left, right and hazard sequences.
module taillight_pattern_monitor
    import taillight_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input logic                        clk,
    input logic                        reset,
    taillight_pattern_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLeft,
        StRight,
        StHaz,
        StSync
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_exp;
    logic [1:0] w_exp_nxt;
    logic       w_done;
    logic       w_err;
    lamp_pat_t  w_pat;
    mode_t      w_pat_mode;
    logic [1:0] w_pat_phase;
    mode_t      w_st_mode;

    mode_t      r_mode;
    logic [1:0] r_phase;
    logic       r_done;
    logic       r_err;
    logic       r_err_flag;
    logic       r_in_sync;

    assign w_pat       = decode_lamps({bus.LA, bus.LB, bus.LC, bus.RA, bus.RB, bus.RC});
    assign w_pat_mode  = pat_mode(w_pat);
    assign w_pat_phase = pat_phase(w_pat);

    always_comb begin
        w_st_mode = ModeOff;
        case (r_state)
            StLeft:  w_st_mode = ModeLeft;
            StRight: w_st_mode = ModeRight;
            StHaz:   w_st_mode = ModeHaz;
            default: w_st_mode = ModeOff;
        endcase
    end

    // r_exp holds the next phase expected; it wraps to 0 once X3 has been seen,
    // after which only OFF is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_pat_phase == 2'd1) begin
                    w_exp_nxt = 2'd2;
                    unique case (w_pat_mode)
                        ModeLeft:  w_state_nxt = StLeft;
                        ModeRight: w_state_nxt = StRight;
                        ModeHaz:   w_state_nxt = StHaz;
                        default:   w_err       = 1'b1;
                    endcase
                end else if (w_pat != PatOff) begin
                    w_err = 1'b1;
                end
            end
            StLeft, StRight, StHaz: begin
                if (r_exp == 2'd0) begin
                    if (w_pat == PatOff) begin
                        w_state_nxt = StIdle;
                        w_done      = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if ((w_pat_mode == w_st_mode) && (w_pat_phase == r_exp)) begin
                    w_exp_nxt = r_exp + 2'd1;
                end else begin
                    w_err = 1'b1;
                end
            end
            StSync: begin
                if (w_pat == PatOff) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_err) begin
            w_state_nxt = StSync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_exp     <= 2'd0;
            r_mode    <= ModeOff;
            r_phase   <= 2'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_in_sync <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_exp     <= w_exp_nxt;
            r_mode    <= w_pat_mode;
            r_phase   <= w_pat_phase;
            r_done    <= w_done;
            r_err     <= w_err;
            r_in_sync <= (w_state_nxt != StSync);
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_flag <= 1'b0;
        end else if (w_err) begin
            r_err_flag <= 1'b1;
        end else if (bus.clr) begin
            r_err_flag <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_left_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_done && (r_state == StLeft)),
        .clr  (bus.clr),
        .count(bus.left_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_right_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_done && (r_state == StRight)),
        .clr  (bus.clr),
        .count(bus.right_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_haz_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_done && (r_state == StHaz)),
        .clr  (bus.clr),
        .count(bus.haz_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (w_err),
        .clr  (bus.clr),
        .count(bus.err_cnt)
    );

    assign bus.mode     = r_mode;
    assign bus.phase    = r_phase;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_flag = r_err_flag;
    assign bus.in_sync  = r_in_sync;

endmodule

// File: tb/tb_taillight_pattern_monitor.sv
// Bench for taillight_pattern_monitor: two instances (CNT_W 8 and 2) share the lamp bus and
// are compared against a grammar-level reference model every cycle.
module tb_taillight_pattern_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] lamps = 6'b0;
    logic       clr_s = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    taillight_pattern_monitor_if #(.CNT_W(8)) bus8 ();
    taillight_pattern_monitor_if #(.CNT_W(2)) bus2 ();

    assign bus8.LA = lamps[5];
    assign bus8.LB = lamps[4];
    assign bus8.LC = lamps[3];
    assign bus8.RA = lamps[2];
    assign bus8.RB = lamps[1];
    assign bus8.RC = lamps[0];
    assign bus8.clr = clr_s;
    assign bus2.LA = lamps[5];
    assign bus2.LB = lamps[4];
    assign bus2.LC = lamps[3];
    assign bus2.RA = lamps[2];
    assign bus2.RB = lamps[1];
    assign bus2.RC = lamps[0];
    assign bus2.clr = clr_s;

    taillight_pattern_monitor #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    taillight_pattern_monitor #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // Reference model state: sequence progress as a run length, raw unbounded counts.
    int m_mode, m_phase, m_fam, m_len;
    int m_left, m_right, m_haz, m_errc;
    bit m_done, m_err, m_flag, m_sync;

    function automatic logic [2:0] thermo(input int k);
        logic [2:0] ones;
        ones = 3'b111;
        return ~(ones >> k);
    endfunction

    function automatic int tlen(input logic [2:0] b);
        for (int k = 0; k < 4; k++) if (thermo(k) == b) return k;
        return -1;
    endfunction

    // fam: 0 off, 1 left, 2 right, 3 hazard
    function automatic logic [5:0] pat(input int fam, input int ph);
        logic [2:0] l, r;
        l = (fam == 1 || fam == 3) ? thermo(ph) : 3'b000;
        r = (fam == 2 || fam == 3) ? thermo(ph) : 3'b000;
        return {l, r};
    endfunction

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_fam = 0; m_len = 0;
        m_left = 0; m_right = 0; m_haz = 0; m_errc = 0;
        m_done = 0; m_err = 0; m_flag = 0; m_sync = 1;
    endtask

    task automatic model_update(input logic [5:0] v, input logic c);
        int l, r, fam, ph, done_fam;
        bit ill, off;
        l = tlen(v[5:3]);
        r = tlen(v[2:0]);
        fam = 0; ph = 0; ill = 0; done_fam = 0;
        if (l < 0 || r < 0) ill = 1;
        else if (l == 0 && r == 0) ill = 0;
        else if (r == 0) begin fam = 1; ph = l; end
        else if (l == 0) begin fam = 2; ph = r; end
        else if (l == r) begin fam = 3; ph = l; end
        else ill = 1;
        off = !ill && fam == 0;
        m_mode = fam; m_phase = ph; m_done = 0; m_err = 0;
        if (!m_sync) begin
            if (off) m_sync = 1;
        end else if (m_len == 0) begin
            if (ph == 1) begin m_fam = fam; m_len = 1; end
            else if (!off) m_err = 1;
        end else if (m_len < 3) begin
            if (fam == m_fam && ph == m_len + 1) m_len++;
            else m_err = 1;
        end else begin
            if (off) begin m_done = 1; done_fam = m_fam; m_len = 0; end
            else m_err = 1;
        end
        if (m_err) begin m_sync = 0; m_len = 0; end
        if (c) begin m_left = 0; m_right = 0; m_haz = 0; m_errc = 0; m_flag = 0; end
        if (done_fam == 1) m_left++;
        if (done_fam == 2) m_right++;
        if (done_fam == 3) m_haz++;
        if (m_err) begin m_errc++; m_flag = 1; end
    endtask

    function automatic logic [55:0] expv();
        logic [7:0] st;
        st = {2'(m_mode), 2'(m_phase), m_done, m_err, m_flag, m_sync};
        return {st, 8'(sat(m_left, 255)), 8'(sat(m_right, 255)), 8'(sat(m_haz, 255)),
                8'(sat(m_errc, 255)), 2'(sat(m_left, 3)), 2'(sat(m_right, 3)),
                2'(sat(m_haz, 3)), 2'(sat(m_errc, 3)), st};
    endfunction

    function automatic logic [55:0] obs();
        return {bus8.mode, bus8.phase, bus8.done, bus8.err, bus8.err_flag, bus8.in_sync,
                bus8.left_cnt, bus8.right_cnt, bus8.haz_cnt, bus8.err_cnt,
                bus2.left_cnt, bus2.right_cnt, bus2.haz_cnt, bus2.err_cnt,
                bus2.mode, bus2.phase, bus2.done, bus2.err, bus2.err_flag, bus2.in_sync};
    endfunction

    task automatic step(input logic [5:0] v, input logic c);
        @(negedge clk);
        reset = 1'b0;
        lamps = v;
        clr_s = c;
        @(posedge clk);
        model_update(v, c);
        #1;
    endtask

    // Lamps and clr are deliberately busy during reset, which must override both.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        lamps = pat(1, 2);
        clr_s = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        clr_s = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs(), expv());
        end
        n_vec++;
        if ({bus8.in_sync, bus8.err_flag, bus8.left_cnt} !== 10'b10_0000_0000) begin
            n_bad++;
            $display("FAIL reset_const: got %b want 1000000000",
                     {bus8.in_sync, bus8.err_flag, bus8.left_cnt});
        end
    endtask

    task automatic test_left_run();
        logic [5:0] q[$];
        do_reset();
        q = {pat(0, 0), pat(1, 1), pat(1, 2), pat(1, 3), pat(0, 0)};
        foreach (q[i]) begin
            step(q[i], 1'b0);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL left_run step %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_vec++;
        if ({bus8.left_cnt, bus8.done, bus8.err, bus8.mode} !== {8'd1, 1'b1, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL left_run_final: got cnt=%0d done=%b err=%b mode=%0d want 1 1 0 0",
                     bus8.left_cnt, bus8.done, bus8.err, bus8.mode);
        end
    endtask

    task automatic test_back_to_back_hazard();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 4; k++) begin
                step(k == 4 ? pat(0, 0) : pat(3, k), 1'b0);
                n_vec++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL hazard_b2b run %0d step %0d: got %h want %h",
                             r, k, obs(), expv());
                end
            end
        end
        n_vec++;
        if ({bus8.haz_cnt, bus8.left_cnt, bus8.right_cnt} !== {8'd2, 8'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL hazard_counts: got h=%0d l=%0d r=%0d want 2 0 0",
                     bus8.haz_cnt, bus8.left_cnt, bus8.right_cnt);
        end
    endtask

    task automatic test_illegal_resync();
        logic [5:0] q[$];
        do_reset();
        q = {pat(2, 1), 6'b101000, pat(2, 2), pat(2, 3), pat(0, 0),
             pat(2, 1), pat(2, 2), pat(2, 3), pat(0, 0)};
        foreach (q[i]) begin
            step(q[i], 1'b0);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL illegal_resync step %0d: got %h want %h", i, obs(), expv());
            end
            if (i == 1) begin
                n_vec++;
                if ({bus8.err, bus8.err_flag, bus8.in_sync, bus8.mode} !== 5'b11000) begin
                    n_bad++;
                    $display("FAIL illegal_err: got %b want 11000",
                             {bus8.err, bus8.err_flag, bus8.in_sync, bus8.mode});
                end
            end
        end
        n_vec++;
        if ({bus8.right_cnt, bus8.err_cnt, bus8.in_sync} !== {8'd1, 8'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL illegal_final: got r=%0d e=%0d sync=%b want 1 1 1",
                     bus8.right_cnt, bus8.err_cnt, bus8.in_sync);
        end
    endtask

    task automatic test_order_violation();
        logic [5:0] q[$];
        do_reset();
        q = {pat(1, 1), pat(1, 3), pat(0, 0), pat(1, 1), pat(1, 2), pat(1, 3), pat(1, 1),
             pat(0, 0)};
        foreach (q[i]) begin
            step(q[i], 1'b0);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL order step %0d: got %h want %h", i, obs(), expv());
            end
        end
        n_vec++;
        if ({bus8.err_cnt, bus8.left_cnt} !== {8'd2, 8'd0}) begin
            n_bad++;
            $display("FAIL order_counts: got e=%0d l=%0d want 2 0", bus8.err_cnt, bus8.left_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int k = 1; k <= 4; k++) begin
                step(k == 4 ? pat(0, 0) : pat(1, k), 1'b0);
                n_vec++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL saturation run %0d step %0d: got %h want %h",
                             r, k, obs(), expv());
                end
            end
        end
        n_vec++;
        if ({bus2.left_cnt, bus8.left_cnt} !== {2'd3, 8'd5}) begin
            n_bad++;
            $display("FAIL saturation_final: got w2=%0d w8=%0d want 3 5",
                     bus2.left_cnt, bus8.left_cnt);
        end
    endtask

    task automatic test_reset_mid_and_clr();
        logic [5:0] q[$];
        do_reset();
        step(pat(1, 1), 1'b0);
        step(pat(1, 2), 1'b0);
        do_reset();
        q = {pat(1, 1), pat(1, 2), pat(1, 3), pat(0, 0)};
        foreach (q[i]) step(q[i], 1'b0);
        n_vec++;
        if ({bus8.left_cnt, bus8.err_cnt} !== {8'd1, 8'd0} || obs() !== expv()) begin
            n_bad++;
            $display("FAIL reset_mid: got %h want %h", obs(), expv());
        end
        // Build up err_cnt, then clear it in the same cycle as a fresh error.
        q = {pat(2, 2), pat(0, 0), pat(2, 1)};
        foreach (q[i]) step(q[i], 1'b0);
        step(pat(2, 3), 1'b1);
        n_vec++;
        if ({bus8.err_flag, bus8.err_cnt, bus8.left_cnt} !== {1'b1, 8'd1, 8'd0}) begin
            n_bad++;
            $display("FAIL clr_with_err: got flag=%b e=%0d l=%0d want 1 1 0",
                     bus8.err_flag, bus8.err_cnt, bus8.left_cnt);
        end
        q = {pat(0, 0), pat(3, 1), pat(3, 2), pat(3, 3)};
        foreach (q[i]) step(q[i], 1'b0);
        step(pat(0, 0), 1'b1);
        n_vec++;
        if ({bus8.haz_cnt, bus8.err_cnt, bus8.err_flag, bus8.done} !== {8'd1, 8'd0, 2'b01}) begin
            n_bad++;
            $display("FAIL clr_with_done: got h=%0d e=%0d flag=%b done=%b want 1 0 0 1",
                     bus8.haz_cnt, bus8.err_cnt, bus8.err_flag, bus8.done);
        end
    endtask

    task automatic test_random();
        int sel, fam;
        logic [5:0] v;
        do_reset();
        for (int it = 0; it < 1200; it++) begin
            sel = $urandom_range(0, 19);
            if (sel < 14) begin
                fam = $urandom_range(1, 3);
                for (int k = 1; k <= 4; k++) begin
                    v = (k == 4) ? pat(0, 0) : pat(fam, k);
                    if ($urandom_range(0, 11) == 0) v = 6'($urandom);
                    step(v, ($urandom_range(0, 29) == 0));
                    n_vec++;
                    if (obs() !== expv()) begin
                        n_bad++;
                        $display("FAIL random it %0d k %0d v %b: got %h want %h",
                                 it, k, v, obs(), expv());
                    end
                end
            end else if (sel == 19) begin
                do_reset();
                n_vec++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL random_reset it %0d: got %h want %h", it, obs(), expv());
                end
            end else begin
                v = (sel < 17) ? 6'($urandom) : pat(0, 0);
                step(v, ($urandom_range(0, 9) == 0));
                n_vec++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL random_noise it %0d v %b: got %h want %h",
                             it, v, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_left_run();
        test_back_to_back_hazard();
        test_illegal_resync();
        test_order_violation();
        test_saturation();
        test_reset_mid_and_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/taillight_pattern_monitor.md
Name: taillight_pattern_monitor

Overview:
- Receiving-end checker for the six-lamp tail-light interface (LA, LB, LC, RA, RB, RC) driven by the turn/hazard sequencer.
- Samples the lamp vector every clock and decodes it into mode and phase.
- Checks every transition against the legal sequence grammar and counts completed left, right and hazard sequences.
- Used in the lab top level for on-board status LEDs and as a self-check in simulation.

Parameters:
- CNT_W, 8, width of each completed-sequence counter and of the error counter; all saturate at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- LA  input  1  left lamp A (innermost).
- LB  input  1  left lamp B.
- LC  input  1  left lamp C (outermost).
- RA  input  1  right lamp A.
- RB  input  1  right lamp B.
- RC  input  1  right lamp C.
- clr  input  1  synchronous clear of err_flag, err_cnt and all sequence counters.
- mode  output  2  decoded mode: 0 OFF, 1 LEFT, 2 RIGHT, 3 HAZARD.
- phase  output  2  decoded phase 0..3; 0 whenever mode is OFF.
- done  output  1  one-cycle pulse when a complete X1->X2->X3->OFF sequence finishes.
- err  output  1  one-cycle pulse on the first illegal pattern or transition.
- err_flag  output  1  sticky error indicator.
- in_sync  output  1  1 when the tracker is aligned to the sequence grammar.
- left_cnt  output  CNT_W  completed left sequences.
- right_cnt  output  CNT_W  completed right sequences.
- haz_cnt  output  CNT_W  completed hazard sequences.
- err_cnt  output  CNT_W  number of err pulses.

Behaviour:
- Pattern decode (combinational, vector {LA,LB,LC,RA,RB,RC}):
  - OFF = 000000.
  - L1 = 100000, L2 = 110000, L3 = 111000.
  - R1 = 000100, R2 = 000110, R3 = 000111.
  - H1 = 100100, H2 = 110110, H3 = 111111.
  - Any other vector = ILLEGAL.
- Tracker FSM states: IDLE, LEFT, RIGHT, HAZ, SYNC. A 2-bit expected-phase register accompanies LEFT/RIGHT/HAZ.
- IDLE:
  - OFF -> stay in IDLE.
  - L1 / R1 / H1 -> LEFT / RIGHT / HAZ with expected phase 2.
  - Anything else -> error.
- LEFT / RIGHT / HAZ, expected phase p:
  - If p is 2 or 3, the same family at phase p -> stay in the state, p+1.
  - If p is 4 (i.e. X3 already seen), OFF -> IDLE, pulse done, increment the matching counter.
  - Anything else -> error.
  - Only OFF may follow X3; X1 directly after X3 is an error.
- Error action:
  - Pulse err for one cycle, set err_flag, increment err_cnt, go to SYNC.
- SYNC:
  - OFF -> IDLE.
  - Everything else -> stay in SYNC, with no further err pulses and no counting.
  - in_sync = 0 only in SYNC.
- Timing:
  - All outputs are registered and reflect the vector sampled at the same edge (one-cycle latency from lamp change to mode/phase).
  - done and err appear in the cycle after the completing or offending sample.
  - mode/phase show the decode of the last sample; an ILLEGAL sample shows mode 0, phase 0.
- Counters saturate and never wrap.
- clr:
  - Zeroes err_flag and all counters.
  - Does not change FSM state.
  - If clr and a new error occur in the same cycle, the error wins: err_flag = 1 and err_cnt = 1.
  - If clr and done occur in the same cycle, the counter ends at 1.
- reset:
  - Every output goes to 0 except in_sync = 1.
  - FSM returns to IDLE; this applies mid-sequence as well.
  - reset has priority over clr.

Decomposition:
- Package taillight_pkg holds:
  - the lamp_pat_t enum (OFF, L1..L3, R1..R3, H1..H3, ILLEGAL);
  - the mode_t enum;
  - the 6-bit pattern constants;
  - the pure decode function.
- Sub-module sat_counter (parameter W; ports inc, clr) is instantiated four times.

Test Plan:
- Left run: OFF, L1, L2, L3, OFF -> mode 1 with phase 1,2,3, then mode 0; done pulse once; left_cnt = 1; err = 0.
- Hazard run: H1, H2, H3, OFF twice back-to-back -> haz_cnt = 2; left_cnt = right_cnt = 0.
- Illegal vector 101000 mid right sequence (R1, 101000) -> err pulse one cycle later, err_flag = 1, in_sync = 0. Further R2, R3 produce no error and no count. After OFF, in_sync = 1, and a following R1..R3, OFF gives right_cnt = 1.
- Order violations: L1 then L3 -> error. L3 then L1 (no OFF between) -> error. err_cnt = 2 after resyncing via OFF in between.
- Saturation with CNT_W = 2: five complete left runs -> left_cnt = 3 and holds.
- Reset and clear: reset asserted after L2 -> all counters 0, IDLE, next L1..L3, OFF counts cleanly. clr asserted in the same cycle as an error -> err_flag = 1, err_cnt = 1.
